// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared period counter.
// Each channel has a double-buffered duty register: writes land in a pending
// register and are copied to the active register only at a period boundary,
// or continuously while the generator is idle. Output polarity per channel
// is applied directly, without buffering.
module pwm_multi_channel #(
  parameter int CH = 4,
  parameter int W  = 8,
  localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [W-1:0]  period,
  input  logic          duty_wr,
  input  logic [SW-1:0] duty_sel,
  input  logic [W-1:0]  duty_data,
  input  logic [CH-1:0] polarity,
  output logic [CH-1:0] pwm_out,
  output logic          period_start
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  // Counter and per-channel state
  logic [W-1:0]  cnt_r;
  logic [W-1:0]  period_act_r;
  logic [W-1:0]  duty_pend_r [CH];
  logic [W-1:0]  duty_act_r  [CH];
  logic [CH-1:0] pwm_out_r;
  logic          period_start_r;

  // Combinational helpers
  logic          boundary_s;
  logic          reload_s;
  logic [W-1:0]  duty_pend_next_s [CH];
  logic [CH-1:0] active_s;
  logic          cnt_is_zero_s;

  assign pwm_out      = pwm_out_r;
  assign period_start = period_start_r;

  // Boundary detection; the active registers reload at a boundary or while idle
  always_comb begin
    boundary_s    = 1'b0;
    reload_s      = 1'b0;
    cnt_is_zero_s = 1'b0;
    if (enable && (cnt_r == period_act_r)) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = 1'b0;
    end
    if (!enable || boundary_s) begin
      reload_s = 1'b1;
    end else begin
      reload_s = 1'b0;
    end
    if (cnt_r == CNT_ZERO) begin
      cnt_is_zero_s = 1'b1;
    end else begin
      cnt_is_zero_s = 1'b0;
    end
  end

  // Pending duty as it will be after this cycle's write; a write in a
  // boundary cycle is therefore picked up for the following period.
  // Selector values without a matching channel never hit and are dropped.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      duty_pend_next_s[i] = duty_pend_r[i];
      if (duty_wr && (duty_sel == SW'(i))) begin
        duty_pend_next_s[i] = duty_data;
      end else begin
        duty_pend_next_s[i] = duty_pend_r[i];
      end
    end
  end

  // Compare the counter with each active duty (unsigned, so duty 0 never
  // fires and any duty above the period keeps the channel fully on)
  always_comb begin
    active_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      if (cnt_r < duty_act_r[i]) begin
        active_s[i] = 1'b1;
      end else begin
        active_s[i] = 1'b0;
      end
    end
  end

  // Pending duty registers accept writes in every cycle, enabled or not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        duty_pend_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        duty_pend_r[i] <= duty_pend_next_s[i];
      end
    end
  end

  // Shared period counter and the period/duty values latched at reload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r        <= CNT_ZERO;
      period_act_r <= CNT_ZERO;
      for (int i = 0; i < CH; i++) begin
        duty_act_r[i] <= CNT_ZERO;
      end
    end else begin
      if (!enable || boundary_s) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (reload_s) begin
        period_act_r <= period;
        for (int i = 0; i < CH; i++) begin
          duty_act_r[i] <= duty_pend_next_s[i];
        end
      end else begin
        period_act_r <= period_act_r;
        for (int i = 0; i < CH; i++) begin
          duty_act_r[i] <= duty_act_r[i];
        end
      end
    end
  end

  // Registered outputs: one cycle behind the counter; idle drives the
  // inactive level on every channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out_r      <= {CH{1'b0}};
      period_start_r <= 1'b0;
    end else begin
      if (enable) begin
        pwm_out_r      <= polarity ^ active_s;
        period_start_r <= cnt_is_zero_s;
      end else begin
        pwm_out_r      <= polarity;
        period_start_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel. Stimulus pushes hand-computed
// per-period expectations (length, active cycles per channel) and per-cycle
// level expectations; a monitor measures the DUT on the falling edge and
// pops/compares whenever a period completes or a level check is due.
module tb_pwm_multi_channel;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] period;
  logic       duty_wr;
  logic [1:0] duty_sel;
  logic [7:0] duty_data;
  logic [3:0] polarity;
  logic [3:0] pwm_out;
  logic       period_start;

  // Second instance with a non power-of-two channel count for selector range
  logic       duty_wr5;
  logic [2:0] duty_sel5;
  logic [4:0] polarity5;
  logic [4:0] pwm_out5;
  logic       period_start5;

  pwm_multi_channel #(.CH(4), .W(8)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_data(duty_data),
    .polarity(polarity), .pwm_out(pwm_out), .period_start(period_start)
  );

  pwm_multi_channel #(.CH(5), .W(8)) u_dut5 (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .duty_wr(duty_wr5), .duty_sel(duty_sel5), .duty_data(duty_data),
    .polarity(polarity5), .pwm_out(pwm_out5), .period_start(period_start5)
  );

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0][15:0] hi;
  } rec_t;

  typedef struct packed {
    logic [3:0] pwm;
    logic       ps;
    logic       chk5;
    logic [4:0] pwm5;
  } lvl_t;

  rec_t rec_q[$];
  lvl_t lvl_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   mon_gen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_rec(input int len, input int h0, input int h1, input int h2, input int h3);
    rec_t r;
    r.len   = 16'(len);
    r.hi[0] = 16'(h0);
    r.hi[1] = 16'(h1);
    r.hi[2] = 16'(h2);
    r.hi[3] = 16'(h3);
    rec_q.push_back(r);
  endtask

  task automatic push_lvl(input logic [3:0] p, input logic ps, input logic c5, input logic [4:0] p5);
    lvl_t l;
    l.pwm  = p;
    l.ps   = ps;
    l.chk5 = c5;
    l.pwm5 = p5;
    lvl_q.push_back(l);
  endtask

  // Monitor: level checks plus per-period measurement on every falling edge
  initial begin
    int         seen;
    logic       in_per;
    int         m_len;
    int         m_hi [4];
    logic [3:0] m_first;
    logic [3:0] act;
    rec_t       e;
    lvl_t       l;
    seen   = 0;
    in_per = 1'b0;
    m_len  = 0;
    m_first = 4'b0000;
    for (int i = 0; i < 4; i++) m_hi[i] = 0;
    forever begin
      @(negedge clk);
      if (mon_gen != seen) begin
        seen   = mon_gen;
        in_per = 1'b0;
      end
      if (lvl_q.size() > 0) begin
        l = lvl_q.pop_front();
        checks++;
        if (pwm_out !== l.pwm) begin
          errors++;
          $display("FAIL pwm_level got %b want %b at %0t", pwm_out, l.pwm, $time);
        end
        checks++;
        if (period_start !== l.ps) begin
          errors++;
          $display("FAIL period_start_level got %b want %b at %0t", period_start, l.ps, $time);
        end
        if (l.chk5) begin
          checks++;
          if (pwm_out5 !== l.pwm5) begin
            errors++;
            $display("FAIL pwm5_level got %b want %b at %0t", pwm_out5, l.pwm5, $time);
          end
          checks++;
          if (period_start5 !== l.ps) begin
            errors++;
            $display("FAIL period_start5_level got %b want %b at %0t", period_start5, l.ps, $time);
          end
        end
      end
      act = pwm_out ^ polarity;
      if (period_start === 1'b1) begin
        if (in_per && (rec_q.size() > 0)) begin
          e = rec_q.pop_front();
          checks++;
          if (m_len != int'(e.len)) begin
            errors++;
            $display("FAIL period_len got %0d want %0d at %0t", m_len, e.len, $time);
          end
          for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_hi[i] != int'(e.hi[i])) begin
              errors++;
              $display("FAIL active_cnt ch%0d got %0d want %0d at %0t", i, m_hi[i], e.hi[i], $time);
            end
            checks++;
            if (m_first[i] !== (e.hi[i] != 16'd0)) begin
              errors++;
              $display("FAIL first_active ch%0d got %b want %b at %0t", i, m_first[i], (e.hi[i] != 16'd0), $time);
            end
          end
        end
        in_per  = 1'b1;
        m_len   = 1;
        m_first = act;
        for (int i = 0; i < 4; i++) m_hi[i] = int'(act[i]);
      end else if (in_per) begin
        m_len++;
        for (int i = 0; i < 4; i++) m_hi[i] += int'(act[i]);
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic write_duty(input int ch, input int val);
    duty_sel  = 2'(ch);
    duty_data = 8'(val);
    duty_wr   = 1'b1;
    @(posedge clk);
    #1;
    duty_wr = 1'b0;
  endtask

  task automatic write_duty5(input int ch, input int val);
    duty_sel5 = 3'(ch);
    duty_data = 8'(val);
    duty_wr5  = 1'b1;
    @(posedge clk);
    #1;
    duty_wr5 = 1'b0;
  endtask

  // Returns in the cycle where the counter is 2 (period_start seen at cnt 1)
  task automatic wait_ps(input int max_cycles);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    while (!found && (n < max_cycles)) begin
      @(negedge clk);
      if (period_start === 1'b1) found = 1'b1;
      n++;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_period_start got timeout want pulse at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  // Must be called right after wait_ps; c >= 2
  task automatic at_cnt(input int c);
    repeat (c - 2) @(posedge clk);
    #1;
  endtask

  task automatic wait_rec_empty(input int max_cycles);
    int n;
    n = 0;
    while ((rec_q.size() != 0) && (n < max_cycles)) begin
      @(posedge clk);
      n++;
    end
    if (rec_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0 at %0t", rec_q.size(), $time);
      rec_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    period    = 8'd99;
    duty_wr   = 1'b0;
    duty_sel  = 2'd0;
    duty_data = 8'd0;
    polarity  = 4'b0000;
    duty_wr5  = 1'b0;
    duty_sel5 = 3'd0;
    polarity5 = 5'b00000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_lvl(4'b0000, 1'b0, 1'b1, 5'b00000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: duties 20/40/60/80, period 100 cycles
    write_duty(0, 20);
    write_duty(1, 40);
    write_duty(2, 60);
    write_duty(3, 80);
    mon_gen++;
    enable = 1'b1;
    push_rec(100, 20, 40, 60, 80);
    push_rec(100, 20, 40, 60, 80);
    wait_rec_empty(400);

    // 2: write 70 at cnt 50, then 30 in the boundary cycle (cnt 99)
    mon_gen++;
    push_rec(100, 20, 40, 60, 80);
    push_rec(100, 70, 40, 60, 80);
    push_rec(100, 30, 40, 60, 80);
    wait_ps(300);
    at_cnt(50);
    write_duty(0, 70);
    wait_ps(300);
    at_cnt(99);
    write_duty(0, 30);
    wait_rec_empty(400);

    // 3: duty 0 never active, duty 255 always active
    write_duty(1, 0);
    write_duty(2, 255);
    wait_ps(300);
    mon_gen++;
    push_rec(100, 30, 0, 100, 80);
    push_rec(100, 30, 0, 100, 80);
    wait_rec_empty(400);

    // 4: inverted polarity on ch1/ch3, then idle drives the inactive level
    polarity = 4'b1010;
    write_duty(0, 20);
    write_duty(1, 40);
    write_duty(2, 60);
    write_duty(3, 80);
    wait_ps(300);
    mon_gen++;
    push_rec(100, 20, 40, 60, 80);
    push_rec(100, 20, 40, 60, 80);
    wait_rec_empty(400);
    enable = 1'b0;
    mon_gen++;
    @(posedge clk);
    #1;
    push_lvl(4'b1010, 1'b0, 1'b0, 5'b00000);
    @(posedge clk);
    #1;
    polarity = 4'b0000;

    // 5: period 9 -> 4 changed at cnt 3, then period 0
    period = 8'd9;
    write_duty(0, 3);
    write_duty(1, 5);
    write_duty(2, 10);
    write_duty(3, 0);
    mon_gen++;
    enable = 1'b1;
    push_rec(10, 3, 5, 10, 0);
    push_rec(5, 3, 5, 5, 0);
    push_rec(5, 3, 5, 5, 0);
    wait_ps(50);
    at_cnt(3);
    period = 8'd4;
    wait_rec_empty(100);
    period = 8'd0;
    mon_gen++;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      push_lvl(4'b0111, 1'b1, 1'b0, 5'b00000);
      @(posedge clk);
      #1;
    end

    // 6: reset at cnt 37 clears everything; selector 5 ignored on 5-channel part
    period = 8'd99;
    write_duty(0, 20);
    write_duty(1, 40);
    write_duty(2, 60);
    write_duty(3, 80);
    wait_ps(300);
    at_cnt(37);
    reset = 1'b1;
    mon_gen++;
    #1;
    push_lvl(4'b0000, 1'b0, 1'b1, 5'b00000);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    write_duty5(5, 50);
    write_duty5(4, 200);
    enable = 1'b1;
    @(posedge clk);
    #1;
    push_lvl(4'b0000, 1'b1, 1'b1, 5'b10000);
    @(posedge clk);
    #1;
    push_lvl(4'b0000, 1'b0, 1'b1, 5'b10000);
    @(posedge clk);
    #1;
    push_lvl(4'b0000, 1'b0, 1'b1, 5'b10000);
    repeat (3) @(posedge clk);
    #1;

    checks++;
    if (lvl_q.size() != 0) begin
      errors++;
      $display("FAIL level_drain got %0d pending want 0", lvl_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
